// File: rtl/lock_pkg.sv
// Shared definitions for the digital lock: entry FSM states, code geometry
// and default timing constants used by code_entry and sequence_check.
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PRESENT = 2'd2,
        LOCKOUT = 2'd3
    } state_e;

    localparam int DIGITS        = 4;
    localparam int DIGIT_W       = 4;
    localparam int SEQ_W         = DIGITS * DIGIT_W;
    localparam int DIGIT_TIMEOUT = 50_000_000;
    localparam int LOCK_CYCLES   = 250_000_000;
    localparam int CNT_W         = 28;

endpackage : lock_pkg

// File: rtl/entry_timer.sv
// Loadable down-counter shared by the inter-digit timeout and the lockout.
// Load wins over counting; the count saturates at zero instead of wrapping.
module entry_timer #(
    parameter int CNT_W = 28
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             count_en,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: reload, decrement while enabled, or hold at zero.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule : entry_timer

// File: rtl/code_entry.sv
// Lock front end: assembles hex key presses into a code, strobes new_seq
// for one cycle when complete, drops stale partial entries after an
// inter-digit timeout, and runs the lockout requested by the checker.
module code_entry #(
    parameter int DIGITS        = lock_pkg::DIGITS,
    parameter int DIGIT_W       = lock_pkg::DIGIT_W,
    parameter int SEQ_W         = DIGITS * DIGIT_W,
    parameter int DIGIT_TIMEOUT = lock_pkg::DIGIT_TIMEOUT,
    parameter int LOCK_CYCLES   = lock_pkg::LOCK_CYCLES,
    parameter int CNT_W         = lock_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_code,
    input  logic               key_clear,
    input  logic               start_time,
    output logic [SEQ_W-1:0]   code_seq,
    output logic               new_seq,
    output logic               times_up,
    output logic [2:0]         digit_count,
    output logic               aborted,
    output logic               locked
);

    import lock_pkg::*;

    localparam logic [CNT_W-1:0] DIGIT_LOAD = CNT_W'(DIGIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LOAD  = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [2:0]       LAST_DIGIT = 3'(DIGITS - 1);

    // A timer too narrow for either duration would silently shorten it.
    if ((longint'(DIGIT_TIMEOUT) > (longint'(1) << CNT_W)) ||
        (longint'(LOCK_CYCLES) > (longint'(1) << CNT_W))) begin : g_cnt_w_check
        $error("code_entry: CNT_W too small for DIGIT_TIMEOUT/LOCK_CYCLES");
    end

    state_e             state_q,       state_d;
    logic [SEQ_W-1:0]   seq_q,         seq_d;
    logic               new_seq_q,     new_seq_d;
    logic               times_up_q,    times_up_d;
    logic [2:0]         digit_count_q, digit_count_d;
    logic               aborted_q,     aborted_d;
    logic               locked_q,      locked_d;

    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_load_value;
    logic               tmr_en;
    logic               tmr_zero;

    entry_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .count_en   (tmr_en),
        .zero       (tmr_zero)
    );

    // Next-state and output decode; start_time > key_clear > key_valid > expiry.
    always_comb begin
        state_d        = state_q;
        seq_d          = seq_q;
        new_seq_d      = 1'b0;
        times_up_d     = times_up_q;
        digit_count_d  = digit_count_q;
        aborted_d      = 1'b0;
        locked_d       = locked_q;
        tmr_load       = 1'b0;
        tmr_load_value = DIGIT_LOAD;
        tmr_en         = 1'b0;

        if (start_time) begin
            // Any partial entry is dropped silently; a running lockout restarts.
            state_d        = LOCKOUT;
            tmr_load       = 1'b1;
            tmr_load_value = LOCK_LOAD;
            times_up_d     = 1'b0;
            locked_d       = 1'b1;
            digit_count_d  = 3'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (key_clear) begin
                        digit_count_d = 3'd0;
                    end else if (key_valid) begin
                        seq_d         = {seq_q[SEQ_W-DIGIT_W-1:0], key_code};
                        digit_count_d = 3'd1;
                        tmr_load      = 1'b1;
                        state_d       = COLLECT;
                    end
                end
                COLLECT: begin
                    tmr_en = 1'b1;
                    if (key_clear) begin
                        digit_count_d = 3'd0;
                        state_d       = IDLE;
                    end else if (key_valid) begin
                        seq_d         = {seq_q[SEQ_W-DIGIT_W-1:0], key_code};
                        digit_count_d = digit_count_q + 3'd1;
                        tmr_load      = 1'b1;
                        if (digit_count_q == LAST_DIGIT) begin
                            new_seq_d = 1'b1;
                            state_d   = PRESENT;
                        end
                    end else if (tmr_zero) begin
                        aborted_d     = 1'b1;
                        digit_count_d = 3'd0;
                        state_d       = IDLE;
                    end
                end
                PRESENT: begin
                    digit_count_d = 3'd0;
                    state_d       = IDLE;
                end
                LOCKOUT: begin
                    tmr_en = 1'b1;
                    if (tmr_zero) begin
                        times_up_d = 1'b1;
                        locked_d   = 1'b0;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            seq_q         <= '0;
            new_seq_q     <= 1'b0;
            times_up_q    <= 1'b1;
            digit_count_q <= 3'd0;
            aborted_q     <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            seq_q         <= seq_d;
            new_seq_q     <= new_seq_d;
            times_up_q    <= times_up_d;
            digit_count_q <= digit_count_d;
            aborted_q     <= aborted_d;
            locked_q      <= locked_d;
        end
    end

    assign code_seq    = seq_q;
    assign new_seq     = new_seq_q;
    assign times_up    = times_up_q;
    assign digit_count = digit_count_q;
    assign aborted     = aborted_q;
    assign locked      = locked_q;

endmodule : code_entry

// File: doc/code_entry.md
Name: code_entry

Overview:
- Front end of the digital lock, on the driving side of the sequence checker.
- Collects hex key presses into a 16-bit code and presents it with a one-cycle new_seq strobe.
- Runs the lockout timer that the checker requests through start_time, and returns times_up to the checker.
- Discards stale partial entries after an inter-digit timeout.

Parameters:
- DIGITS, 4, number of hex digits per code.
- DIGIT_W, 4, bits per key code.
- SEQ_W, DIGITS*DIGIT_W = 16, width of sequence.
- DIGIT_TIMEOUT, 50_000_000, max cycles between accepted digits before the partial entry is discarded.
- LOCK_CYCLES, 250_000_000, lockout duration in cycles after start_time.
- CNT_W, 28, timer counter width; must hold max(DIGIT_TIMEOUT, LOCK_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; key_code is valid.
- key_code  in  4  hex digit pressed.
- key_clear  in  1  one-cycle strobe; discard the partial entry.
- start_time  in  1  one-cycle request from the checker to start a lockout.
- sequence  out  16  assembled code; first digit in bits [15:12].
- new_seq  out  1  one-cycle strobe; sequence holds a complete code.
- times_up  out  1  level; lockout expired, entry re-enabled.
- digit_count  out  3  digits accepted in the current entry, 0..4.
- aborted  out  1  one-cycle strobe; partial entry discarded by timeout.
- locked  out  1  high while the lockout is running.

Behaviour:
- Reset values (asynchronous, immediate): sequence=0, new_seq=0, times_up=1, digit_count=0, aborted=0, locked=0, state=IDLE, timer=0.
- All outputs are registered.
- IDLE:
  - key_valid: sequence <= {sequence[11:0], key_code}, digit_count=1, timer loads DIGIT_TIMEOUT-1, go COLLECT.
- COLLECT:
  - key_valid: shift in the digit, digit_count+1, reload the timer.
  - On the 4th digit: go PRESENT.
  - Timer reaches 0 with no key: aborted=1 for one cycle, digit_count=0, go IDLE. Sequence is not cleared.
  - key_clear: digit_count=0, go IDLE, aborted stays 0.
- PRESENT (exactly one cycle):
  - new_seq=1; sequence equals the four digits in press order. Keys 1,2,3,4 give 16'h1234.
  - new_seq asserts the cycle after the 4th key_valid edge (latency 1).
  - Next state is IDLE with digit_count=0. key_valid in this cycle is ignored.
- LOCKOUT:
  - Entered from any state on start_time.
  - Timer loads LOCK_CYCLES-1; times_up=0 and locked=1 from the next cycle.
  - A partial entry is discarded without an aborted pulse. key_valid and key_clear are ignored.
  - Timer reaches 0: times_up=1, locked=0, go IDLE.
- times_up stays high until the next start_time.
- Priority in a single cycle: start_time > key_clear > key_valid > timer expiry.
- start_time during LOCKOUT reloads the timer and extends the lockout.
- key_valid in the same cycle as DIGIT_TIMEOUT expiry: the key is accepted and the timer reloads; no abort.
- sequence holds its last complete or partial value between entries. The checker samples it only on new_seq.
- Timer is a decrementing counter with no wrap below 0. Values are truncated to CNT_W; CNT_W too small is a configuration error.
- Reset asserted mid-entry or mid-lockout returns everything to the reset values with no strobes.

Decomposition:
- Shared package lock_pkg:
  - state encoding (IDLE, COLLECT, PRESENT, LOCKOUT),
  - SEQ_W and DIGIT_W constants,
  - default timing constants, also used by sequence_check.
- One sub-module, entry_timer:
  - loadable down-counter (load, load_value, count enable),
  - zero flag,
  - same clk/reset.

Test Plan (DIGIT_TIMEOUT=6, LOCK_CYCLES=8):
- Reset, then keys 1,2,3,4 on consecutive cycles -> new_seq=1 one cycle after key 4, sequence=16'h1234, digit_count returns to 0.
- Keys A,B then 7 idle cycles -> aborted pulses once on the 6th idle cycle, digit_count=0; next keys 2,5,8,0 give sequence=16'h2580 with new_seq.
- Keys 1,1, key_clear, then key_valid in the same cycle as a second key_clear -> no digit accepted, digit_count=0, no aborted; then 1,1,2,2 gives 16'h1122.
- start_time pulse -> times_up=0 and locked=1 for 8 cycles, then times_up=1; keys pressed during the lockout produce no new_seq and digit_count stays 0.
- start_time at lockout cycle 5 -> lockout extends to 8 cycles from the second pulse.
- start_time in the same cycle as the 3rd digit of 1,0,1 -> LOCKOUT, digit_count=0, no new_seq; reset asserted mid-lockout -> times_up=1 immediately.
